rf_spi_master: RTL and testbench
================================

RF_SPI_MASTER -- requirements
Module: rf_spi_master

Interface
REQ-001 Parameter: CLK_DIV, 5, SCLK half-period in clk cycles (H); legal range 2..255.
REQ-002 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 cs_in  input  1  transaction request from the RF control FSM; level signal, its rising edge starts a frame.
REQ-005 inst  input  2  bit1 = long address (1) or short address (0); bit0 = write (1) or read (0).
REQ-006 addr_in  input  10  register address; short frames use addr_in[5:0] only.
REQ-007 data_in  input  8  write data; ignored for reads.
REQ-008 ready  output  1  high only when idle and able to accept a request.
REQ-009 rd_data  output  8  last read byte; held until the next read completes.
REQ-010 rd_valid  output  1  one-cycle pulse when a read completes.
REQ-011 spi_cs_n  output  1  transceiver chip select, active low.
REQ-012 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 spi_mosi  output  1  serial data to the transceiver, MSB first.
REQ-014 spi_miso  input  1  serial data from the transceiver.

Function
REQ-015 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, CS_HIGH and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, cs_in high with its previous-cycle sample low SHALL accept the request and latch inst, addr_in and data_in.
REQ-017 A cs_in level held high after a frame completes SHALL NOT retrigger a frame.
REQ-018 cs_in edges while not IDLE SHALL be dropped, not queued.
REQ-019 A short frame SHALL be 16 bits: {0, addr[5:0], w, data[7:0]}.
REQ-020 A long frame SHALL be 24 bits: {1, addr[9:0], w, 4'b0000, data[7:0]}.
REQ-021 For reads, the 8 data-phase MOSI bits SHALL be 0.
REQ-022 On accept (edge T0), the outputs at T0 SHALL be ready=0, spi_cs_n=0, spi_sclk=0, spi_mosi=frame MSB; the FSM SHALL enter SETUP.
REQ-023 SETUP: H cycles with sclk low, then SHIFT_HI.
REQ-024 SHIFT_HI: sclk=1 for H cycles; miso SHALL be sampled on entry (rising SCLK edge) into a shift register.
REQ-025 SHIFT_LO: sclk=0 for H cycles; mosi SHALL advance to the next bit on entry (falling edge); after bit N's low phase, go to CS_HIGH.
REQ-026 Bit counter: 5 bits, loaded with N-1 (15 or 23), decremented per SHIFT_LO, frame ends at 0; no wrap.
REQ-027 CS_HIGH: spi_cs_n=1, sclk=0, mosi=0 for H cycles, then DONE.
REQ-028 DONE: one cycle, then IDLE; for reads, rd_data SHALL take the last 8 sampled bits and rd_valid SHALL pulse once; writes SHALL leave rd_data unchanged with no pulse.
REQ-029 ready SHALL return to 1 at edge T0+(2N+2)*H+1: 171 cycles for short frames and 251 for long frames at CLK_DIV=5.
REQ-030 ready SHALL fall within one cycle of a cs_in rising edge, so the control FSM's 3-cycle wait observes it low.
REQ-031 Half-period counter: 8 bits, reloaded on every state change, no wrap.

Reset
REQ-032 rst_n low at a clk edge SHALL force IDLE, ready=1, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rd_data=0x00, rd_valid=0, and clear all counters and the cs_in edge register.
REQ-033 Reset mid-frame SHALL abort immediately with spi_cs_n=1 on the same edge; no rd_valid is produced.
REQ-034 A cs_in held high through reset release SHALL NOT start a frame until it goes low and high again.

Verification
REQ-035 Short read, addr 0x31, MISO data 0xA5 -> MOSI 0x62,0x00; rd_data=0xA5; rd_valid pulses once; ready high 171 cycles after accept.
REQ-036 Long read, addr 0x200, MISO 0x3C -> MOSI 0xC000 then 0x00; rd_data=0x3C; 251-cycle busy.
REQ-037 Long write, addr 0x000, data 0x7E -> MOSI 0x8010,0x7E; no rd_valid; rd_data unchanged.
REQ-038 cs_in held high across completion, plus a second edge mid-frame -> exactly one frame; ready stays 1 afterwards.
REQ-039 rst_n low at bit 10 of a long write -> spi_cs_n=1 and ready=1 next edge; no further SCLK edges.
REQ-040 CLK_DIV=2 short write, addr 0x2A, data 0x55 -> MOSI 0x5555; SCLK period 4 cycles; ready after 69 cycles.

Source files
------------

// File: rtl/rf_spi_master.sv
// SPI master for the RF transceiver: serialises 16-bit short or 24-bit long register frames in SPI mode 0.
// It captures the read byte from MISO. All outputs are registered.
module rf_spi_master #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_in,
  input  logic [1:0] inst,
  input  logic [9:0] addr_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, CS_HIGH, DONE} state_t;

  state_t      state_r, state_s;
  logic [7:0]  hcnt_r, hcnt_s;
  logic [4:0]  bcnt_r, bcnt_s;
  logic [23:0] tx_r, tx_s;
  logic [7:0]  rx_r, rx_s;
  logic        is_read_r, is_read_s;
  logic        cs_q_r, cs_armed_r;
  logic        ready_s, cs_n_s, sclk_s, mosi_s, rd_valid_s;
  logic [7:0]  rd_data_s;
  logic [23:0] frame_s;
  logic        accept_s;

  // Left-aligned frame image; read frames carry zeros in the data phase.
  always_comb begin
    frame_s = 24'd0;
    if (inst[1]) begin
      frame_s = {1'b1, addr_in, inst[0], 4'b0000, (inst[0] ? data_in : 8'h00)};
    end else begin
      frame_s = {1'b0, addr_in[5:0], inst[0], (inst[0] ? data_in : 8'h00), 8'h00};
    end
  end

  // cs_armed_r blocks a level that was already high across reset release.
  assign accept_s = (state_r == IDLE) && cs_in && !cs_q_r && cs_armed_r;

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    hcnt_s     = hcnt_r;
    bcnt_s     = bcnt_r;
    tx_s       = tx_r;
    rx_s       = rx_r;
    is_read_s  = is_read_r;
    ready_s    = ready;
    cs_n_s     = spi_cs_n;
    sclk_s     = spi_sclk;
    mosi_s     = spi_mosi;
    rd_data_s  = rd_data;
    rd_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = SETUP;
          hcnt_s    = HALF_LOAD;
          bcnt_s    = inst[1] ? 5'd23 : 5'd15;
          tx_s      = {frame_s[22:0], 1'b0};
          mosi_s    = frame_s[23];
          is_read_s = !inst[0];
          ready_s   = 1'b0;
          cs_n_s    = 1'b0;
          sclk_s    = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      SETUP: begin
        if (hcnt_r == 8'd0) begin
          state_s = SHIFT_HI;
          hcnt_s  = HALF_LOAD;
          sclk_s  = 1'b1;
          rx_s    = {rx_r[6:0], spi_miso};
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (hcnt_r == 8'd0) begin
          state_s = SHIFT_LO;
          hcnt_s  = HALF_LOAD;
          sclk_s  = 1'b0;
          mosi_s  = tx_r[23];
          tx_s    = {tx_r[22:0], 1'b0};
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      SHIFT_LO: begin
        if (hcnt_r != 8'd0) begin
          hcnt_s = hcnt_r - 8'd1;
        end else if (bcnt_r == 5'd0) begin
          state_s = CS_HIGH;
          hcnt_s  = HALF_LOAD;
          cs_n_s  = 1'b1;
          mosi_s  = 1'b0;
        end else begin
          state_s = SHIFT_HI;
          hcnt_s  = HALF_LOAD;
          bcnt_s  = bcnt_r - 5'd1;
          sclk_s  = 1'b1;
          rx_s    = {rx_r[6:0], spi_miso};
        end
      end
      CS_HIGH: begin
        if (hcnt_r == 8'd0) begin
          state_s = DONE;
          hcnt_s  = HALF_LOAD;
          if (is_read_r) begin
            rd_data_s  = rx_r;
            rd_valid_s = 1'b1;
          end else begin
            rd_valid_s = 1'b0;
          end
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        hcnt_s  = 8'd0;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        hcnt_s  = 8'd0;
        bcnt_s  = 5'd0;
        ready_s = 1'b1;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hcnt_r     <= 8'd0;
      bcnt_r     <= 5'd0;
      tx_r       <= 24'd0;
      rx_r       <= 8'd0;
      is_read_r  <= 1'b0;
      cs_q_r     <= 1'b0;
      cs_armed_r <= ~cs_in;
      ready      <= 1'b1;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
    end else begin
      state_r    <= state_s;
      hcnt_r     <= hcnt_s;
      bcnt_r     <= bcnt_s;
      tx_r       <= tx_s;
      rx_r       <= rx_s;
      is_read_r  <= is_read_s;
      cs_q_r     <= cs_in;
      cs_armed_r <= cs_armed_r | ~cs_in;
      ready      <= ready_s;
      spi_cs_n   <= cs_n_s;
      spi_sclk   <= sclk_s;
      spi_mosi   <= mosi_s;
      rd_data    <= rd_data_s;
      rd_valid   <= rd_valid_s;
    end
  end

endmodule

// File: tb/tb_rf_spi_master.sv
// Bench for rf_spi_master: drives a CLK_DIV=5 and a CLK_DIV=2 instance and acts as the SPI slave.
// Frames, busy time and read bytes are predicted from the frame rules.
module tb_rf_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cs0, cs1, miso;
  logic [1:0] inst;
  logic [9:0] addr;
  logic [7:0] data;
  logic       ready0, rd_valid0, cs_n0, sclk0, mosi0;
  logic       ready1, rd_valid1, cs_n1, sclk1, mosi1;
  logic [7:0] rd_data0, rd_data1;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int last_rd[2];

  logic       m_ready, m_rd_valid, m_cs_n, m_sclk, m_mosi;
  logic [7:0] m_rd_data;
  assign m_ready    = (sel == 1) ? ready1    : ready0;
  assign m_rd_valid = (sel == 1) ? rd_valid1 : rd_valid0;
  assign m_cs_n     = (sel == 1) ? cs_n1     : cs_n0;
  assign m_sclk     = (sel == 1) ? sclk1     : sclk0;
  assign m_mosi     = (sel == 1) ? mosi1     : mosi0;
  assign m_rd_data  = (sel == 1) ? rd_data1  : rd_data0;

  rf_spi_master #(.CLK_DIV(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs_in(cs0), .inst(inst), .addr_in(addr), .data_in(data),
    .ready(ready0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .spi_cs_n(cs_n0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso));

  rf_spi_master #(.CLK_DIV(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs_in(cs1), .inst(inst), .addr_in(addr), .data_in(data),
    .ready(ready1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .spi_cs_n(cs_n1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso));

  task automatic set_cs(input int s, input logic v);
    if (s == 1) cs1 = v;
    else cs0 = v;
  endtask

  // One full frame on instance s, with the bench acting as the SPI slave.
  task automatic run_frame(input string tag, input int s, input logic [1:0] i, input logic [9:0] a,
                           input logic [7:0] d, input logic [23:0] slave_bits,
                           input bit toggle_mid, input bit keep_high);
    int h, n, ef, exp_busy, c, rises, last_rise, vcount, captured, exp_rd, idle_err;
    bit period_err, is_wr;
    logic prev;
    logic [23:0] sb;
    h = (s == 1) ? 2 : 5;
    n = i[1] ? 24 : 16;
    is_wr = i[0];
    if (i[1]) ef = (1 << 23) + (int'(a) << 13) + (int'(is_wr) << 12) + (is_wr ? int'(d) : 0);
    else      ef = ((int'(a) % 64) << 9) + (int'(is_wr) << 8) + (is_wr ? int'(d) : 0);
    exp_busy = (2 * n + 2) * h + 1;
    exp_rd = is_wr ? last_rd[s] : ((int'(slave_bits) >> (24 - n)) % 256);
    sel = s; inst = i; addr = a; data = d;
    set_cs(s, 1'b1);
    @(posedge clk); #1;
    c = 0; rises = 0; last_rise = 0; vcount = 0; captured = 0; period_err = 1'b0;
    total++;
    if ({m_ready, m_cs_n, m_sclk, m_mosi} !== {1'b0, 1'b0, 1'b0, 1'(ef >> (n - 1))}) begin
      bad++;
      $display("FAIL %s accept: got rdy/csn/sclk/mosi=%b%b%b%b want 000%0d", tag,
               m_ready, m_cs_n, m_sclk, m_mosi, (ef >> (n - 1)) % 2);
    end
    sb = slave_bits;
    miso = sb[23];
    sb = sb << 1;
    prev = m_sclk;
    while (m_ready == 1'b0 && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (!keep_high && c == 3) set_cs(s, 1'b0);
      if (toggle_mid && c == 20) set_cs(s, 1'b0);
      if (toggle_mid && c == 25) set_cs(s, 1'b1);
      if (m_sclk && !prev) begin
        captured = (captured << 1) + int'(m_mosi);
        rises++;
        if (rises == 1 && c != h) period_err = 1'b1;
        if (rises > 1 && (c - last_rise) != 2 * h) period_err = 1'b1;
        last_rise = c;
      end
      if (!m_sclk && prev) begin
        miso = sb[23];
        sb = sb << 1;
      end
      if (m_rd_valid) vcount++;
      prev = m_sclk;
    end
    total++;
    if (c !== exp_busy) begin bad++; $display("FAIL %s busy: got %0d want %0d", tag, c, exp_busy); end
    total++;
    if (rises !== n) begin bad++; $display("FAIL %s sclk_rises: got %0d want %0d", tag, rises, n); end
    total++;
    if (captured !== ef) begin bad++; $display("FAIL %s mosi: got %h want %h", tag, captured, ef); end
    total++;
    if (period_err) begin bad++; $display("FAIL %s sclk_period: got irregular want %0d", tag, 2 * h); end
    total++;
    if (vcount !== (is_wr ? 0 : 1)) begin
      bad++; $display("FAIL %s rd_valid_count: got %0d want %0d", tag, vcount, is_wr ? 0 : 1);
    end
    total++;
    if (int'(m_rd_data) !== exp_rd) begin
      bad++; $display("FAIL %s rd_data: got %h want %h", tag, m_rd_data, exp_rd);
    end
    last_rd[s] = exp_rd;
    if (keep_high) begin
      idle_err = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (m_ready !== 1'b1 || m_cs_n !== 1'b1) idle_err++;
      end
      total++;
      if (idle_err !== 0) begin bad++; $display("FAIL %s retrigger: got %0d busy cycles want 0", tag, idle_err); end
      set_cs(s, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ready0, cs_n0, sclk0, mosi0, rd_valid0, rd_data0} !== {5'b11000, 8'h00}) begin
      bad++;
      $display("FAIL reset0: got %b%b%b%b%b %h want 11000 00", ready0, cs_n0, sclk0, mosi0, rd_valid0, rd_data0);
    end
    total++;
    if ({ready1, cs_n1, sclk1, rd_valid1, rd_data1} !== {4'b1100, 8'h00}) begin
      bad++; $display("FAIL reset1: got %b%b%b%b %h want 1100 00", ready1, cs_n1, sclk1, rd_valid1, rd_data1);
    end
    rst_n = 1'b1;
    last_rd[0] = 0;
    last_rd[1] = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_short_read();
    run_frame("short_read", 0, 2'b00, 10'h031, 8'h00, 24'h5AA500, 1'b0, 1'b0);
  endtask

  task automatic test_long_read();
    run_frame("long_read", 0, 2'b10, 10'h200, 8'h00, 24'h96C33C, 1'b0, 1'b0);
  endtask

  task automatic test_long_write();
    run_frame("long_write", 0, 2'b11, 10'h000, 8'h7E, 24'hFFFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_hold_retrigger();
    run_frame("hold_retrigger", 0, 2'b01, 10'h015, 8'hC3, 24'h123456, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      run_frame("random", (k >= 7) ? 1 : 0, 2'($urandom_range(0, 3)), 10'($urandom),
                8'($urandom), 24'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic test_clkdiv2();
    run_frame("div2_write", 1, 2'b01, 10'h02A, 8'h55, 24'h000000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int c, rises, err;
    logic prev;
    sel = 0; inst = 2'b11; addr = 10'h155; data = 8'hA7;
    cs0 = 1'b1;
    @(posedge clk); #1;
    c = 0; rises = 0; prev = sclk0;
    while (rises < 10 && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (sclk0 && !prev) rises++;
      prev = sclk0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cs_n0, ready0, sclk0, rd_valid0} !== 4'b1100) begin
      bad++; $display("FAIL reset_abort: got csn/rdy/sclk/vld=%b%b%b%b want 1100", cs_n0, ready0, sclk0, rd_valid0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cs0 = 1'b0;
    err = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (sclk0 !== 1'b0 || cs_n0 !== 1'b1 || rd_valid0 !== 1'b0) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL reset_quiet: got %0d active cycles want 0", err); end
    last_rd[0] = 0;
    last_rd[1] = 0;
  endtask

  task automatic test_held_through_reset();
    int err;
    cs0 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready0 !== 1'b1 || cs_n0 !== 1'b1) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL held_through_reset: got %0d busy cycles want 0", err); end
    cs0 = 1'b0;
    @(posedge clk); #1;
    run_frame("after_rearm", 0, 2'b00, 10'h03F, 8'h00, 24'h00E700, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; miso = 1'b0;
    inst = 2'b00; addr = 10'd0; data = 8'd0;
    last_rd[0] = 0; last_rd[1] = 0;
    test_reset();
    test_short_read();
    test_long_read();
    test_long_write();
    test_hold_retrigger();
    test_random();
    test_clkdiv2();
    test_reset_midframe();
    test_held_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
